// File: rtl/prpg_sequencer.sv
// prpg_sequencer: micro-programmed controller for a PRPG datapath.
// Fetches 14-bit instructions from a 64-entry program RAM and issues
// one-cycle datapath pulses (config, seed load, LFSR run, store, load).
module prpg_sequencer #(
   parameter int PROG_DEPTH = 64,
   parameter int MEM_LIMIT  = 226
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        prog_we,
   input  logic [5:0]  prog_addr,
   input  logic [13:0] prog_data,
   input  logic        start,
   output logic        cfg_en,
   output logic [6:0]  tap,
   output logic        seed_en,
   output logic [7:0]  seed,
   output logic        run_en,
   output logic        st_en,
   output logic        ld_en,
   output logic [7:0]  mem_addr,
   output logic [5:0]  pc,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_RUN,
      S_DONE
   } state_t;

   typedef enum logic [5:0] {
      OP_HALT      = 6'd0,
      OP_CONFIG    = 6'd1,
      OP_INIT      = 6'd2,
      OP_RUN       = 6'd3,
      OP_INIT_ADDR = 6'd4,
      OP_ST        = 6'd5,
      OP_ADD_ADDR  = 6'd6,
      OP_LD        = 6'd7
   } op_t;

   localparam logic [8:0] LIMIT   = 9'(MEM_LIMIT);
   localparam logic [5:0] LAST_PC = 6'(PROG_DEPTH - 1);

   logic [13:0] ram [PROG_DEPTH];
   logic [13:0] rd_word;
   logic [13:0] ir;
   logic [5:0]  op;
   logic [7:0]  opd;
   logic [7:0]  cnt;
   state_t      state, state_nx;
   logic        last, addr_bad;
   logic        pc_inc, err_set, addr_load, addr_add, cnt_load;

   assign rd_word  = ram[pc];
   assign op       = ir[13:8];
   assign opd      = ir[7:0];
   assign last     = (pc == LAST_PC);
   assign addr_bad = ({1'b0, mem_addr} >= LIMIT);

   // Program RAM: writable only while idle, never cleared by reset.
   always_ff @(posedge clk) begin
      if (prog_we && state == S_IDLE)
         ram[prog_addr] <= prog_data;
   end

   // Next-state and pulse decode; pulses are combinational from state/ir.
   always_comb begin
      state_nx  = state;
      cfg_en    = 1'b0;
      seed_en   = 1'b0;
      st_en     = 1'b0;
      ld_en     = 1'b0;
      run_en    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      pc_inc    = 1'b0;
      err_set   = 1'b0;
      addr_load = 1'b0;
      addr_add  = 1'b0;
      cnt_load  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nx = S_FETCH;
         end
         S_FETCH: begin
            busy     = 1'b1;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            busy     = 1'b1;
            state_nx = last ? S_DONE : S_FETCH;
            pc_inc   = !last;
            case (op)
               OP_HALT: begin
                  state_nx = S_DONE;
                  pc_inc   = 1'b0;
               end
               OP_CONFIG:    cfg_en    = 1'b1;
               OP_INIT:      seed_en   = 1'b1;
               OP_INIT_ADDR: addr_load = 1'b1;
               OP_ADD_ADDR:  addr_add  = 1'b1;
               OP_RUN: begin
                  cnt_load = 1'b1;
                  state_nx = S_RUN;
                  pc_inc   = 1'b0;
               end
               OP_ST, OP_LD: begin
                  if (addr_bad) begin
                     err_set  = 1'b1;
                     state_nx = S_DONE;
                     pc_inc   = 1'b0;
                  end else begin
                     st_en = (op == OP_ST);
                     ld_en = (op == OP_LD);
                  end
               end
               default: begin
                  err_set  = 1'b1;
                  state_nx = S_DONE;
                  pc_inc   = 1'b0;
               end
            endcase
         end
         S_RUN: begin
            busy   = 1'b1;
            run_en = 1'b1;
            if (cnt == 8'd1) begin
               state_nx = last ? S_DONE : S_FETCH;
               pc_inc   = !last;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, program counter, instruction register and datapath operand registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= '0;
         mem_addr <= '0;
         tap      <= '0;
         seed     <= '0;
         cnt      <= '0;
         ir       <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            pc  <= '0;
            err <= 1'b0;
         end else if (pc_inc) begin
            pc <= pc + 6'd1;
         end
         if (err_set)
            err <= 1'b1;
         // tap/seed are captured at fetch so they are valid alongside the EXEC pulse.
         if (state == S_FETCH) begin
            ir <= rd_word;
            if (rd_word[13:8] == OP_CONFIG)
               tap <= rd_word[6:0];
            if (rd_word[13:8] == OP_INIT)
               seed <= rd_word[7:0];
         end
         if (addr_load)
            mem_addr <= opd;
         else if (addr_add)
            mem_addr <= mem_addr + opd;
         if (cnt_load)
            cnt <= (opd == '0) ? 8'd1 : opd;
         else if (run_en)
            cnt <= cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_prpg_sequencer.sv
// Self-checking bench for prpg_sequencer: directed and random programs
// compared against an instruction-level reference model.
module tb_prpg_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [13:0] prog_data;
   logic        start;
   logic        cfg_en, seed_en, run_en, st_en, ld_en;
   logic [6:0]  tap;
   logic [7:0]  seed, mem_addr;
   logic [5:0]  pc;
   logic        busy, done, err;

   prpg_sequencer #(.PROG_DEPTH(64), .MEM_LIMIT(226)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .cfg_en(cfg_en), .tap(tap),
      .seed_en(seed_en), .seed(seed), .run_en(run_en), .st_en(st_en),
      .ld_en(ld_en), .mem_addr(mem_addr), .pc(pc), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Event kinds: 1 config(tap) 2 init(seed) 3 run(length) 4 st(addr) 5 ld(addr)
   typedef struct {
      int kind;
      int val;
   } ev_t;

   int          total = 0;
   int          bad   = 0;
   logic [13:0] prog [64];
   ev_t         exp_q[$];
   ev_t         got_q[$];
   int          m_tap, m_seed, m_addr, m_pc, m_err, m_busy;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [13:0] ins(input int op, input int opd);
      return {6'(op), 8'(opd)};
   endfunction

   task automatic clear_prog;
      for (int i = 0; i < 64; i++) prog[i] = 14'h0;
   endtask

   task automatic load_prog;
      for (int i = 0; i < 64; i++) begin
         prog_we   = 1'b1;
         prog_addr = 6'(i);
         prog_data = prog[i];
         tick;
      end
      prog_we = 1'b0;
   endtask

   // Instruction-level interpretation of the program: events, busy cycles, final state.
   task automatic model;
      int  p, op, opd, n;
      bit  stop;
      exp_q.delete();
      p = 0; m_err = 0; m_busy = 0; stop = 0;
      while (!stop) begin
         op  = int'(prog[p][13:8]);
         opd = int'(prog[p][7:0]);
         m_busy += 2;
         if (op == 0) begin
            stop = 1;
         end else if (op == 1) begin
            m_tap = opd % 128;
            exp_q.push_back('{1, m_tap});
         end else if (op == 2) begin
            m_seed = opd;
            exp_q.push_back('{2, opd});
         end else if (op == 3) begin
            n = (opd == 0) ? 1 : opd;
            m_busy += n;
            exp_q.push_back('{3, n});
         end else if (op == 4) begin
            m_addr = opd;
         end else if (op == 6) begin
            m_addr = (m_addr + opd) % 256;
         end else if (op == 5 || op == 7) begin
            if (m_addr >= 226) begin
               m_err = 1;
               stop  = 1;
            end else begin
               exp_q.push_back('{(op == 5) ? 4 : 5, m_addr});
            end
         end else begin
            m_err = 1;
            stop  = 1;
         end
         if (!stop) begin
            if (p == 63) stop = 1;
            else p++;
         end
      end
      m_pc = p;
   endtask

   task automatic run_prog(input bit disturb, input bit we_start, input logic [5:0] wa,
                           input logic [13:0] wd, input string name);
      int cyc, run_len, busy_cnt, nmin;
      bit seen_done;
      got_q.delete();
      start = 1'b1; prog_we = we_start; prog_addr = wa; prog_data = wd;
      tick;
      start = 1'b0; prog_we = 1'b0;
      cyc = 0; run_len = 0; busy_cnt = 0; seen_done = 0;
      while (!seen_done && cyc < 20000) begin
         check({name, "_onehot"}, int'($countones({cfg_en, seed_en, run_en, st_en, ld_en}) <= 1), 1);
         if (busy) busy_cnt++;
         if (run_en) run_len++;
         else if (run_len > 0) begin
            got_q.push_back('{3, run_len});
            run_len = 0;
         end
         if (cfg_en)  got_q.push_back('{1, int'(tap)});
         if (seed_en) got_q.push_back('{2, int'(seed)});
         if (st_en)   got_q.push_back('{4, int'(mem_addr)});
         if (ld_en)   got_q.push_back('{5, int'(mem_addr)});
         if (done) begin
            seen_done = 1;
         end else begin
            if (disturb && cyc == 2) begin
               start = 1'b1; prog_we = 1'b1; prog_addr = 6'd2; prog_data = 14'h3F00;
            end else begin
               start = 1'b0; prog_we = 1'b0;
            end
            tick;
            cyc++;
         end
      end
      start = 1'b0; prog_we = 1'b0;
      check({name, "_done_seen"}, int'(seen_done), 1);
      model;
      check({name, "_ev_count"}, got_q.size(), exp_q.size());
      nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) begin
         check($sformatf("%s_ev%0d_kind", name, i), got_q[i].kind, exp_q[i].kind);
         check($sformatf("%s_ev%0d_val", name, i), got_q[i].val, exp_q[i].val);
      end
      check({name, "_busy_cycles"}, busy_cnt, m_busy);
      check({name, "_err"}, int'(err), m_err);
      check({name, "_pc"}, int'(pc), m_pc);
      check({name, "_mem_addr"}, int'(mem_addr), m_addr);
      check({name, "_tap_hold"}, int'(tap), m_tap);
      check({name, "_seed_hold"}, int'(seed), m_seed);
      check({name, "_busy_at_done"}, int'(busy), 0);
      tick;
      check({name, "_done_one_cycle"}, int'(done), 0);
      check({name, "_idle_after"}, int'(busy), 0);
   endtask

   task automatic rand_prog;
      int r, op, opd;
      for (int i = 0; i < 64; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0) op = 0;
         else if (r == 1) op = $urandom_range(8, 63);
         else op = 1 + (r % 7);
         opd = (op == 3) ? $urandom_range(0, 5) : $urandom_range(0, 255);
         prog[i] = ins(op, opd);
      end
   endtask

   initial begin
      int  k;
      rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      m_tap = 0; m_seed = 0; m_addr = 0;
      tick; tick;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(err), 0);
      check("rst_pc", int'(pc), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_tap", int'(tap), 0);
      check("rst_seed", int'(seed), 0);
      check("rst_pulses", int'({cfg_en, seed_en, run_en, st_en, ld_en}), 0);
      rst = 1'b0;
      tick;

      // Basic config/init/run/halt, with start and a RAM write attempted while busy.
      clear_prog;
      prog[0] = ins(1, 8'h25); prog[1] = ins(2, 8'hFF); prog[2] = ins(3, 2); prog[3] = ins(0, 0);
      load_prog;
      run_prog(1, 0, '0, '0, "basic");
      run_prog(0, 0, '0, '0, "basic_rerun");

      // Write to pc 0 in the same cycle as start.
      prog[0] = ins(1, 8'h11);
      run_prog(0, 1, 6'd0, ins(1, 8'h11), "we_start");

      // Address arithmetic wraps modulo 256.
      clear_prog;
      prog[0] = ins(4, 8'h09); prog[1] = ins(5, 0); prog[2] = ins(6, 8'hFE);
      prog[3] = ins(5, 0); prog[4] = ins(6, 8'h02); prog[5] = ins(7, 0);
      load_prog;
      run_prog(0, 0, '0, '0, "addr_wrap");

      // Run length edge cases.
      clear_prog;
      prog[0] = ins(3, 0);
      load_prog;
      run_prog(0, 0, '0, '0, "run0");
      prog[0] = ins(3, 8'hFF);
      load_prog;
      run_prog(0, 0, '0, '0, "run255");

      // Memory limit: first illegal address and last legal address.
      clear_prog;
      prog[0] = ins(4, 8'hE2); prog[1] = ins(5, 0);
      load_prog;
      run_prog(0, 0, '0, '0, "limit_bad");
      prog[0] = ins(4, 8'hE1); prog[1] = ins(5, 0); prog[2] = ins(7, 0);
      load_prog;
      run_prog(0, 0, '0, '0, "limit_ok");

      // Illegal opcode at pc 3.
      clear_prog;
      prog[0] = ins(4, 1); prog[1] = ins(6, 2); prog[2] = ins(1, 3); prog[3] = 14'h3F00;
      load_prog;
      run_prog(0, 0, '0, '0, "illegal");

      // 64 non-halting words: ends after pc 63 without error.
      for (int i = 0; i < 64; i++) prog[i] = ins(4, i);
      prog[63] = ins(3, 3);
      load_prog;
      run_prog(0, 0, '0, '0, "no_halt");

      // Random programs.
      for (int t = 0; t < 8; t++) begin
         rand_prog;
         load_prog;
         run_prog(t[0], 0, '0, '0, $sformatf("rand%0d", t));
      end

      // Reset in the middle of a run.
      clear_prog;
      prog[0] = ins(3, 10);
      load_prog;
      start = 1'b1;
      tick;
      start = 1'b0;
      k = 0;
      while (!run_en && k < 20) begin
         tick;
         k++;
      end
      check("rst_mid_run_reached", int'(run_en), 1);
      repeat (5) tick;
      #2;
      rst = 1'b1;
      #1;
      m_tap = 0; m_seed = 0; m_addr = 0;
      check("rst_mid_run_en", int'(run_en), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_pc", int'(pc), 0);
      check("rst_mid_err", int'(err), 0);
      check("rst_mid_done", int'(done), 0);
      tick;
      rst = 1'b0;
      repeat (3) tick;
      check("rst_idle_busy", int'(busy), 0);
      check("rst_idle_run_en", int'(run_en), 0);
      run_prog(0, 0, '0, '0, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prpg_sequencer.md
PRPG_SEQUENCER -- requirements
Module: prpg_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 64, program RAM entries; fixed at 64 and addressed by a 6-bit pc.
REQ-002 Parameter MEM_LIMIT, default 226, first illegal pattern-memory address.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 prog_we  input  1  program RAM write strobe.
REQ-006 prog_addr  input  6  program RAM write address.
REQ-007 prog_data  input  14  instruction word: opcode [13:8], operand [7:0].
REQ-008 start  input  1  one-cycle request to execute the program from pc=0.
REQ-009 cfg_en  output  1  one-cycle pulse: datapath latches tap.
REQ-010 tap  output  7  tap vector, operand[6:0] of config.
REQ-011 seed_en  output  1  one-cycle pulse: datapath loads seed.
REQ-012 seed  output  8  seed value, operand[7:0] of init.
REQ-013 run_en  output  1  per-cycle LFSR advance enable.
REQ-014 st_en  output  1  one-cycle pulse: store LFSR state to mem_addr.
REQ-015 ld_en  output  1  one-cycle pulse: load LFSR state from mem_addr.
REQ-016 mem_addr  output  8  pattern-memory address register.
REQ-017 pc  output  6  current program counter.
REQ-018 busy  output  1  high from the cycle after an accepted start until the cycle DONE is entered.
REQ-019 done  output  1  one-cycle pulse on normal completion.
REQ-020 err  output  1  sticky error flag, cleared by the next accepted start or by rst.

Function
REQ-021 Opcodes: 000000 halt; 000001 config; 000010 init; 000011 run; 000100 init_addr; 000101 st; 000110 add_addr; 000111 ld; all others illegal.
REQ-022 The FSM shall have states IDLE, FETCH, EXEC, RUN and DONE.
REQ-023 IDLE: start=1 -> FETCH with pc=0, err=0; start is ignored in every other state.
REQ-024 FETCH: synchronous program RAM read at pc; the word is registered into the instruction register -> EXEC.
REQ-025 EXEC config/init/st/ld: assert the matching pulse for exactly one cycle with operand outputs valid in the same cycle, pc+1 -> FETCH.
REQ-026 EXEC init_addr: mem_addr=operand; add_addr: mem_addr=(mem_addr+operand) mod 256; no pulse; pc+1 -> FETCH.
REQ-027 EXEC run: load an 8-bit down-counter with operand, treating 0 as 1 -> RUN.
REQ-028 RUN: run_en=1 each cycle while the counter decrements; on the cycle the counter reaches 1, pc+1 -> FETCH; run_en is high for exactly N consecutive cycles.
REQ-029 EXEC halt -> DONE with no pulse.
REQ-030 EXEC illegal opcode -> err=1 -> DONE, with no datapath pulse.
REQ-031 EXEC st/ld with mem_addr>=MEM_LIMIT: suppress the pulse, err=1 -> DONE.
REQ-032 pc wrap: an instruction executed at pc=63 that does not halt -> DONE; pc does not wrap to 0.
REQ-033 DONE: done=1 for one cycle, busy=0 -> IDLE; pc and mem_addr hold their values.
REQ-034 Program RAM writes are accepted only in IDLE; prog_we is ignored when busy.
REQ-035 start and prog_we asserted together in IDLE: the write completes and start is accepted in the same cycle.
REQ-036 tap and seed hold their last driven value between pulses.
REQ-037 At most one of cfg_en, seed_en, run_en, st_en and ld_en is high in any cycle.

Reset
REQ-038 rst=1 asynchronously forces IDLE, pc=0, mem_addr=0, tap=0, seed=0, run counter=0, and deasserts all pulses, busy, done and err.
REQ-039 Program RAM contents are not cleared by rst.
REQ-040 rst asserted mid-run ends run_en immediately; after release the block idles until the next start.

Verification
REQ-041 Load {config 0x25, init 0xFF, run 2, halt}, pulse start -> cfg_en@tap=0x25, seed_en@seed=0xFF, run_en for 2 cycles, done pulse; err=0; total 10 cycles from start to done.
REQ-042 Program {init_addr 0x09, st, add_addr 0xFE, st, add_addr 0x02, ld, halt} -> st_en at mem_addr 0x09 then 0x07, ld_en at 0x09 (verifies mod-256 add).
REQ-043 Program {run 0, halt} -> run_en exactly 1 cycle; program {run 0xFF, halt} -> run_en exactly 255 contiguous cycles.
REQ-044 Program {init_addr 0xE2, st} -> no st_en, err=1, done pulse, pc=1.
REQ-045 Opcode 0x3F at pc=3 -> err=1 and done; 64 non-halt words -> done after pc=63 with err=0.
REQ-046 Assert rst during RUN at count 5 -> run_en=0 in the same cycle, busy=0; a start after release reruns the program from pc=0 with the RAM intact.
